i2s_audio_tx: RTL and testbench

- Serialises the Atari core's stereo PCM stream onto the board I2S pins I2S_BCK, I2S_LRCK and I2S_DATA.
- These pins are mirrored to the HDMI audio pins at top level.
- Sits directly downstream of the POKEY/covox mixer output.
- A one-entry holding buffer with a valid/ready handshake decouples the mixer's sample rate from the I2S frame rate; on underrun the last frame is repeated.

---
 rtl/audio_pkg.sv | 12 +
 rtl/i2s_audio_tx_if.sv | 15 +
 rtl/i2s_bck_gen.sv | 32 +++
 rtl/i2s_audio_tx.sv | 98 +++++++++
 tb/tb_i2s_audio_tx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the stereo I2S transmit path.
package audio_pkg;

  localparam int SAMPLE_BITS_DFLT = 16;
  localparam int UNDERRUN_MAX     = 255;

  typedef struct packed {
    logic signed [SAMPLE_BITS_DFLT-1:0] left;
    logic signed [SAMPLE_BITS_DFLT-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Mixer-to-I2S sample handshake: one stereo word per valid/ready transfer, plus mute.
interface i2s_audio_tx_if #(
  parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS_DFLT
) ();

  logic signed [SAMPLE_BITS-1:0] AUDIO_L;
  logic signed [SAMPLE_BITS-1:0] AUDIO_R;
  logic                          SAMPLE_VALID;
  logic                          SAMPLE_READY;
  logic                          MUTE;

  modport master (output AUDIO_L, AUDIO_R, SAMPLE_VALID, MUTE, input SAMPLE_READY);
  modport slave  (input AUDIO_L, AUDIO_R, SAMPLE_VALID, MUTE, output SAMPLE_READY);

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: BCK toggles every BCK_DIV cycles; bck_fall marks the cycle BCK goes 1->0.
module i2s_bck_gen #(
  parameter int BCK_DIV = 9
) (
  input  logic clk,
  input  logic rst,
  output logic bck,
  output logic bck_fall
);

  localparam int DIV_W = $clog2(BCK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             at_end;

  assign at_end   = (div_cnt == DIV_W'(BCK_DIV - 1));
  // Combinational so the top updates LRCK/DATA on the same edge that drops BCK.
  assign bck_fall = at_end && bck;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (at_end) begin
      div_cnt <= '0;
      bck     <= ~bck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-format I2S serialiser with a one-entry sample buffer; repeats the last frame on underrun.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DFLT,
  parameter int BCK_DIV     = 9
) (
  input  logic          CLK,
  input  logic          RESET,
  i2s_audio_tx_if.slave bus,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA,
  output logic [7:0]    UNDERRUN_CNT
);

  localparam int W     = SAMPLE_BITS;
  localparam int CNT_W = $clog2(2 * W);
  localparam int IDX_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(2 * W - 1);

  typedef struct packed {
    logic signed [W-1:0] left;
    logic signed [W-1:0] right;
  } frame_t;

  logic             bck, bck_fall;
  logic [CNT_W-1:0] bit_cnt, slot;
  frame_t           hold, frame;
  logic             full, ready, lrck, data, data_next, load, take;
  logic [7:0]       underrun;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'(UNDERRUN_MAX)) ? v : v + 8'd1;
  endfunction

  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clk      (CLK),
    .rst      (RESET),
    .bck      (bck),
    .bck_fall (bck_fall)
  );

  // Slot 0 still carries the outgoing frame's right LSB; the new frame starts at slot 1.
  always_comb begin
    slot      = (bit_cnt == LAST_SLOT) ? '0 : bit_cnt + 1'b1;
    data_next = frame.right[0];
    if (slot != '0 && int'(slot) <= W)
      data_next = frame.left[IDX_W'(W - int'(slot))];
    else if (int'(slot) > W)
      data_next = frame.right[IDX_W'(2 * W - int'(slot))];
  end

  assign load = bck_fall && (slot == '0);
  assign take = bus.SAMPLE_VALID && ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt  <= LAST_SLOT;
      lrck     <= 1'b0;
      data     <= 1'b0;
      ready    <= 1'b0;
      full     <= 1'b0;
      hold     <= '0;
      frame    <= '0;
      underrun <= '0;
    end else begin
      if (bck_fall) begin
        bit_cnt <= slot;
        lrck    <= (int'(slot) >= W);
        data    <= data_next;
      end
      if (load && full)
        frame <= bus.MUTE ? '0 : hold;
      else if (load)
        underrun <= sat_inc(underrun);
      // ready tracks ~full; a load and a transfer can never coincide.
      if (take) begin
        hold.left  <= bus.AUDIO_L;
        hold.right <= bus.AUDIO_R;
        full       <= 1'b1;
        ready      <= 1'b0;
      end else if (load && full) begin
        full  <= 1'b0;
        ready <= 1'b1;
      end else begin
        ready <= ~full;
      end
    end
  end

  assign bus.SAMPLE_READY = ready;
  assign I2S_BCK          = bck;
  assign I2S_LRCK         = lrck;
  assign I2S_DATA         = data;
  assign UNDERRUN_CNT     = underrun;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx with BCK_DIV=2, 16-bit words; frames captured per falling BCK.
module tb_i2s_audio_tx;
  import audio_pkg::*;

  localparam int W   = 16;
  localparam int DIV = 2;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] l;
  } frame_rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bck, lrck, data;
  logic [7:0] ucnt;

  int n_vec  = 0;
  int n_miss = 0;

  frame_rec_t frames[$];
  frame_rec_t cur;
  int         mon_slot = 31;
  logic       prev_bck = 1'b0;

  i2s_audio_tx_if #(.SAMPLE_BITS(W)) bus ();

  i2s_audio_tx #(.SAMPLE_BITS(W), .BCK_DIV(DIV)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .bus          (bus),
    .I2S_BCK      (bck),
    .I2S_LRCK     (lrck),
    .I2S_DATA     (data),
    .UNDERRUN_CNT (ucnt)
  );

  always #5 clk = ~clk;

  // Record DATA/LRCK at each falling BCK, indexed by slot; push a frame at slot 31.
  always @(negedge clk) begin
    if (prev_bck && !bck) begin
      mon_slot = (mon_slot + 1) % 32;
      cur.d[mon_slot] = data;
      cur.l[mon_slot] = lrck;
      if (mon_slot == 31) frames.push_back(cur);
    end
    prev_bck = bck;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_d(input logic [15:0] l, input logic [15:0] r, input logic p);
    logic [31:0] v;
    v[0] = p;
    for (int s = 1; s <= 16; s++) v[s] = l[16 - s];
    for (int s = 17; s <= 31; s++) v[s] = r[32 - s];
    return v;
  endfunction

  task automatic clear_mon();
    frames.delete();
    mon_slot = 31;
    prev_bck = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.SAMPLE_VALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bck", bck, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", bus.SAMPLE_READY, 0);
    chk("rst_underrun", ucnt, 0);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (frames.size() < n && guard < n * 200 + 400) begin
      @(negedge clk);
      guard++;
    end
    if (frames.size() < n) chk("frame_timeout", frames.size(), n);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int guard = 0;
    while (bus.SAMPLE_READY !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", bus.SAMPLE_READY, 1);
    bus.AUDIO_L = l;
    bus.AUDIO_R = r;
    bus.SAMPLE_VALID = 1'b1;
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b0;
    chk("send_taken", bus.SAMPLE_READY, 0);
  endtask

  initial begin
    int cyc, r1, r2, g, acc, rdy_cyc, run, max_run, bad;
    logic last, pending;
    stereo_sample_t smp[8];
    logic [31:0] rep;

    rst = 1'b1;
    bus.AUDIO_L = '0;
    bus.AUDIO_R = '0;
    bus.SAMPLE_VALID = 1'b0;
    bus.MUTE = 1'b0;

    // Idle after reset: BCK period, silent framing, first underrun.
    do_reset();
    @(negedge clk);
    chk("ready_after_rst", bus.SAMPLE_READY, 1);
    cyc = 0; r1 = -1; r2 = -1; last = bck;
    while (r2 < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!last && bck) begin
        if (r1 < 0) r1 = cyc; else r2 = cyc;
      end
      last = bck;
    end
    chk("bck_period", r2 - r1, 2 * DIV);
    wait_frames(1);
    chk("idle_data", frames[0].d, 32'h0000_0000);
    chk("idle_lrck", frames[0].l, 32'hFFFF_0000);
    chk("idle_underrun", ucnt, 1);

    // Single sample offered before the first load.
    do_reset();
    send(16'h8001, 16'h7FFE);
    wait_frames(2);
    chk("single_frame", frames[0].d, 32'hFFFD_0002);
    chk("single_lrck", frames[0].l, 32'hFFFF_0000);
    chk("single_repeat", frames[1].d, 32'hFFFD_0002);
    chk("single_next_slot0", frames[1].d[0], 0);
    chk("single_underrun", ucnt, 1);

    // Back-to-back: VALID held high, new sample after every acceptance.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      smp[k].left  = 16'h8000 ^ (16'(k) * 16'h1357);
      smp[k].right = 16'h00FF + 16'(k) * 16'h2222;
    end
    acc = 0; rdy_cyc = 0; run = 0; max_run = 0; g = 0; pending = 1'b0;
    bus.AUDIO_L = smp[0].left;
    bus.AUDIO_R = smp[0].right;
    bus.SAMPLE_VALID = 1'b1;
    while (frames.size() < 6 && g < 2000) begin
      @(negedge clk);
      g++;
      if (pending) begin
        acc++;
        bus.AUDIO_L = smp[acc % 8].left;
        bus.AUDIO_R = smp[acc % 8].right;
      end
      pending = bus.SAMPLE_READY;
      if (pending) begin
        rdy_cyc++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    bus.SAMPLE_VALID = 1'b0;
    chk("b2b_accepts", acc, 7);
    chk("b2b_ready_cycles", rdy_cyc, 7);
    chk("b2b_ready_run", max_run, 1);
    chk("b2b_underrun", ucnt, 0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("b2b_frame%0d", k), frames[k].d,
          exp_d(smp[k].left, smp[k].right, (k == 0) ? 1'b0 : smp[k - 1].right[0]));

    // MUTE at load with all-ones buffered.
    do_reset();
    bus.MUTE = 1'b1;
    send(16'hFFFF, 16'hFFFF);
    wait_frames(1);
    chk("mute_frame", frames[0].d, 32'h0000_0000);
    chk("mute_ready", bus.SAMPLE_READY, 1);
    chk("mute_underrun", ucnt, 0);
    bus.MUTE = 1'b0;

    // Starvation: repeat last frame, saturate counter.
    do_reset();
    send(16'h5A3C, 16'hC3A5);
    wait_frames(11);
    chk("starve_cnt10", ucnt, 10);
    wait_frames(301);
    chk("starve_first", frames[0].d, exp_d(16'h5A3C, 16'hC3A5, 1'b0));
    rep = exp_d(16'h5A3C, 16'hC3A5, 1'b1);
    bad = 0;
    for (int k = 1; k < 301; k++)
      if (frames[k].d !== rep || frames[k].l !== 32'hFFFF_0000) bad++;
    chk("starve_repeat_errs", bad, 0);
    chk("starve_sat", ucnt, 255);

    // Reset pulse in the right word (slot 18 carries a 1).
    g = 0;
    while (mon_slot != 18 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("slot_wait", mon_slot, 18);
    chk("pre_rst_data", data, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bck", bck, 0);
    chk("midrst_lrck", lrck, 0);
    chk("midrst_data", data, 0);
    chk("midrst_ready", bus.SAMPLE_READY, 0);
    chk("midrst_underrun", ucnt, 0);
    rst = 1'b0;
    clear_mon();
    send(16'h0F0F, 16'hF0F1);
    wait_frames(1);
    chk("post_rst_frame", frames[0].d, exp_d(16'h0F0F, 16'hF0F1, 1'b0));
    chk("post_rst_lrck", frames[0].l, 32'hFFFF_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
